spi_driver_pair: RTL and testbench
==================================

// Module: spi_driver_pair
// PURPOSE
//  SPI master and SPI slave byte engines in one block for loopback and bring-up.
//  Master: on start, runs one 8-bit full-duplex SPI transfer and returns the received byte.
//  Slave: oversamples an external SPI bus and shifts out a preloaded byte.
//  Slave returns the byte received when CS deasserts.
//  Mode 0 (CPOL=0, CPHA=0), MSB first, one CS.
// PARAMETERS
//  SCLK_HALF  4  master SCLK half-period in clk_i cycles; must be >=4 (slave sync margin)
// PORTS
//  clk_i        in   1  system clock; all logic on rising edge
//  rst_i        in   1  synchronous reset, active-low
//  m_start_i    in   1  master: request a transfer (level, sampled while m_ready_o=1)
//  m_data_in_bi in   8  master: byte to transmit
//  m_ready_o    out  1  master: 1 = idle, result valid
//  m_data_out_bo out 8  master: last byte received on MISO
//  m_miso_i     in   1  master SPI MISO
//  m_mosi_o     out  1  master SPI MOSI
//  m_sclk_o     out  1  master SPI SCLK
//  m_cs_o       out  1  master SPI CS, active-low
//  s_data_in_bi in   8  slave: byte to transmit; latched at CS fall
//  s_ready_o    out  1  slave: 1 = no transfer in progress
//  s_data_out_bo out 8  slave: last complete byte received on MOSI
//  s_miso_o     out  1  slave SPI MISO
//  s_mosi_i     in   1  slave SPI MOSI
//  s_sclk_i     in   1  slave SPI SCLK
//  s_cs_i       in   1  slave SPI CS, active-low
// BEHAVIOUR
//  Reset (rst_i=0 at a clock edge), including mid-transfer:
//   - m_ready_o=1, m_cs_o=1, m_sclk_o=0, m_mosi_o=0, m_data_out_bo=0.
//   - s_ready_o=1, s_miso_o=0, s_data_out_bo=0.
//   - All shift registers and counters cleared.
//  Master FSM: IDLE -> SETUP -> HIGH <-> LOW (8 bits) -> DONE -> IDLE.
//   - IDLE: m_ready_o=1, CS=1, SCLK=0.
//   - IDLE with m_start_i=1: latch m_data_in_bi; next state SETUP.
//   - SETUP (SCLK_HALF cycles): CS=0, m_ready_o=0, MOSI=bit7.
//   - HIGH (SCLK_HALF cycles): SCLK=1; sample MISO into rx shift register on entry.
//   - LOW (SCLK_HALF cycles): SCLK=0; on entry shift tx; MOSI = next bit.
//   - After 8th LOW: DONE for 1 cycle. CS=1, m_data_out_bo<=rx, m_ready_o=1 from the following cycle.
//   - m_ready_o is low for exactly 17*SCLK_HALF+1 cycles (69 at default).
//   - m_start_i is ignored while busy.
//   - If m_start_i is still high when back in IDLE, a new transfer begins.
//  Slave:
//   - Sync: 2-FF synchronizers on s_sclk_i, s_cs_i, s_mosi_i; edge detect on synced values.
//   - CS fall: latch s_data_in_bi; s_miso_o=bit7; bit count=0; s_ready_o=0.
//   - SCLK rise while CS=0: shift synced MOSI into rx; count++.
//   - SCLK fall while CS=0: shift tx; s_miso_o = next bit.
//   - CS rise with count=8: s_data_out_bo<=rx; s_ready_o=1.
//   - CS rise with count!=8: abort; s_data_out_bo unchanged; s_ready_o=1.
//   - Edges beyond 8 bits are ignored.
//   - s_miso_o=0 whenever synced CS=1.
//   - Latency from an input SPI edge to the slave's reaction: 3 clk_i cycles.
// STRUCTURE
//  - Package spi_drv_pkg holds: SPI_BITS=8, master state enum, SCLK_HALF range check.
//  - Two sub-modules, no shared state between them:
//    - spi_master_core: FSM, clock divider, shift registers.
//    - spi_slave_core: synchronizers, edge detect, shift registers.
//  - This module instantiates both and wires ports straight through.
// TESTING (bench ties m_mosi_o->s_mosi_i, m_sclk_o->s_sclk_i, m_cs_o->s_cs_i, s_miso_o->m_miso_i)
//  1. Reset held 5 cycles -> all outputs at reset values; ready_o both 1.
//  2. m_data_in=0x5A, s_data_in=0x69, m_start 2 cycles -> m_data_out=0x69, s_data_out=0x5A.
//     Also check: m_ready_o low 69 cycles; exactly 8 SCLK pulses.
//  3. Back-to-back transfers 0xFF/0x00 then 0x00/0xFF -> exchanged bytes correct each time.
//     Check CS=1 at least 1 cycle between transfers.
//  4. Reset asserted mid-transfer (after 3 SCLK pulses) -> next cycle CS=1, SCLK=0, ready=1.
//     Then a new 0xA5/0x3C exchange completes correctly.
//  5. Drive slave directly: CS low, 4 SCLK pulses, CS high -> s_data_out_bo unchanged, s_ready_o=1.
//  6. m_start held high continuously -> consecutive transfers; m_data_in change picked up at the next start.

Source files
------------

// File: rtl/spi_drv_pkg.sv
// Shared definitions for the SPI master/slave byte engine pair.
package spi_drv_pkg;

  // Bits per SPI transfer (one byte, MSB first).
  localparam int SPI_BITS = 8;

  // Smallest legal master SCLK half-period. The slave needs three clk cycles
  // to react to an SCLK edge and one more so its MISO update lands before the
  // master samples it on the next SCLK rise.
  localparam int SCLK_HALF_MIN = 4;

  // Master sequencer states.
  typedef enum logic [2:0] {
    M_IDLE,
    M_SETUP,
    M_HIGH,
    M_LOW,
    M_DONE
  } master_state_t;

  // True when a requested SCLK half-period leaves the slave enough margin.
  function automatic bit sclk_half_valid(input int half);
    return half >= SCLK_HALF_MIN;
  endfunction

endpackage

// File: rtl/spi_master_core.sv
// SPI mode-0 master: runs one full-duplex byte transfer per start request.
module spi_master_core
  import spi_drv_pkg::*;
#(
  parameter int SCLK_HALF = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SPI_BITS-1:0] tx_byte,
  output logic                ready,
  output logic [SPI_BITS-1:0] rx_byte,
  input  logic                miso,
  output logic                mosi,
  output logic                sclk,
  output logic                cs
);

  localparam int CNT_W = $clog2(SCLK_HALF + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
  localparam logic [3:0] BIT_TOTAL = 4'(SPI_BITS);

  master_state_t       state;
  logic [CNT_W-1:0]    phase_cnt;
  logic [3:0]          bit_cnt;
  logic [SPI_BITS-1:0] tx_shift;
  logic [SPI_BITS-1:0] rx_shift;
  logic                phase_end;

  assign phase_end = (phase_cnt == HALF_LAST);

  // Sequencer, SCLK divider and shift registers; every SPI pin is registered
  // so the bus never glitches between states. MISO is captured on each SCLK
  // rise and MOSI advances on each SCLK fall. The tx register rotates rather
  // than shifts so it holds no dead bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= M_IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      ready     <= 1'b1;
      rx_byte   <= '0;
      mosi      <= 1'b0;
      sclk      <= 1'b0;
      cs        <= 1'b1;
    end else begin
      case (state)
        M_IDLE: begin
          if (start) begin
            tx_shift  <= tx_byte;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            mosi      <= tx_byte[SPI_BITS-1];
            cs        <= 1'b0;
            ready     <= 1'b0;
            state     <= M_SETUP;
          end
        end
        M_SETUP: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sclk      <= 1'b1;
            rx_shift  <= {rx_shift[SPI_BITS-2:0], miso};
            bit_cnt   <= bit_cnt + 4'd1;
            state     <= M_HIGH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        M_HIGH: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sclk      <= 1'b0;
            tx_shift  <= {tx_shift[SPI_BITS-2:0], tx_shift[SPI_BITS-1]};
            mosi      <= tx_shift[SPI_BITS-2];
            state     <= M_LOW;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        M_LOW: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (bit_cnt == BIT_TOTAL) begin
              cs      <= 1'b1;
              mosi    <= 1'b0;
              rx_byte <= rx_shift;
              state   <= M_DONE;
            end else begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[SPI_BITS-2:0], miso};
              bit_cnt  <= bit_cnt + 4'd1;
              state    <= M_HIGH;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        M_DONE: begin
          ready <= 1'b1;
          state <= M_IDLE;
        end
        default: begin
          state <= M_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: oversamples an external bus with clk and exchanges one byte.
module spi_slave_core
  import spi_drv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SPI_BITS-1:0] tx_byte,
  output logic                ready,
  output logic [SPI_BITS-1:0] rx_byte,
  output logic                miso,
  input  logic                mosi,
  input  logic                sclk,
  input  logic                cs
);

  localparam logic [3:0] BIT_TOTAL = 4'(SPI_BITS);

  logic cs_meta, cs_sync, cs_prev;
  logic sclk_meta, sclk_sync, sclk_prev;
  logic mosi_meta, mosi_sync;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [SPI_BITS-1:0] tx_shift;
  logic [SPI_BITS-1:0] rx_shift;
  logic [3:0]          bit_cnt;

  // Two-stage synchronizers plus a delayed copy for edge detection. Reset
  // puts them in the idle-bus state so leaving reset never looks like a CS fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign cs_fall   =  cs_prev   & ~cs_sync;
  assign cs_rise   = ~cs_prev   &  cs_sync;
  assign sclk_rise = ~sclk_prev &  sclk_sync;
  assign sclk_fall =  sclk_prev & ~sclk_sync;

  // Byte engine: CS edges frame the transfer, SCLK edges shift inside it.
  // Only a frame with exactly eight captured bits updates the output byte;
  // edges past the eighth bit are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      ready    <= 1'b1;
      miso     <= 1'b0;
    end else if (cs_fall) begin
      tx_shift <= tx_byte;
      rx_shift <= '0;
      bit_cnt  <= '0;
      miso     <= tx_byte[SPI_BITS-1];
      ready    <= 1'b0;
    end else if (cs_rise) begin
      if (bit_cnt == BIT_TOTAL) begin
        rx_byte <= rx_shift;
      end
      ready <= 1'b1;
      miso  <= 1'b0;
    end else if (cs_sync) begin
      miso <= 1'b0;
    end else begin
      if (sclk_rise && (bit_cnt < BIT_TOTAL)) begin
        rx_shift <= {rx_shift[SPI_BITS-2:0], mosi_sync};
        bit_cnt  <= bit_cnt + 4'd1;
      end
      if (sclk_fall && (bit_cnt < BIT_TOTAL)) begin
        tx_shift <= {tx_shift[SPI_BITS-2:0], tx_shift[SPI_BITS-1]};
        miso     <= tx_shift[SPI_BITS-2];
      end
    end
  end

endmodule

// File: rtl/spi_driver_pair.sv
// SPI master and slave byte engines side by side for loopback and bring-up.
module spi_driver_pair
  import spi_drv_pkg::*;
#(
  parameter int SCLK_HALF = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m_start_i,
  input  logic [SPI_BITS-1:0] m_data_in_bi,
  output logic                m_ready_o,
  output logic [SPI_BITS-1:0] m_data_out_bo,
  input  logic                m_miso_i,
  output logic                m_mosi_o,
  output logic                m_sclk_o,
  output logic                m_cs_o,
  input  logic [SPI_BITS-1:0] s_data_in_bi,
  output logic                s_ready_o,
  output logic [SPI_BITS-1:0] s_data_out_bo,
  output logic                s_miso_o,
  input  logic                s_mosi_i,
  input  logic                s_sclk_i,
  input  logic                s_cs_i
);

  // A shorter half-period would let the master sample MISO before the slave
  // has updated it.
  if (!sclk_half_valid(SCLK_HALF)) begin : g_bad_sclk_half
    $error("spi_driver_pair: SCLK_HALF must be at least %0d", SCLK_HALF_MIN);
  end

  spi_master_core #(
    .SCLK_HALF(SCLK_HALF)
  ) u_master (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .start   (m_start_i),
    .tx_byte (m_data_in_bi),
    .ready   (m_ready_o),
    .rx_byte (m_data_out_bo),
    .miso    (m_miso_i),
    .mosi    (m_mosi_o),
    .sclk    (m_sclk_o),
    .cs      (m_cs_o)
  );

  spi_slave_core u_slave (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .tx_byte (s_data_in_bi),
    .ready   (s_ready_o),
    .rx_byte (s_data_out_bo),
    .miso    (s_miso_o),
    .mosi    (s_mosi_i),
    .sclk    (s_sclk_i),
    .cs      (s_cs_i)
  );

endmodule

// File: tb/tb_spi_driver_pair.sv
// Loopback bench for spi_driver_pair: master wired to slave, plus direct slave drive.
module tb_spi_driver_pair;

  localparam int HALF    = 4;
  localparam int EXP_LOW = 17 * HALF + 1;

  logic       clk;
  logic       rst;
  logic       m_start;
  logic [7:0] m_data_in;
  logic       m_ready;
  logic [7:0] m_data_out;
  logic       m_miso;
  logic       m_mosi;
  logic       m_sclk;
  logic       m_cs;
  logic [7:0] s_data_in;
  logic       s_ready;
  logic [7:0] s_data_out;
  logic       s_miso;
  logic       s_mosi;
  logic       s_sclk;
  logic       s_cs;

  logic direct;
  logic b_cs, b_sclk, b_mosi;

  int checks = 0;
  int passes = 0;

  assign s_mosi = direct ? b_mosi : m_mosi;
  assign s_sclk = direct ? b_sclk : m_sclk;
  assign s_cs   = direct ? b_cs   : m_cs;
  assign m_miso = s_miso;

  spi_driver_pair #(
    .SCLK_HALF(HALF)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_start_i     (m_start),
    .m_data_in_bi  (m_data_in),
    .m_ready_o     (m_ready),
    .m_data_out_bo (m_data_out),
    .m_miso_i      (m_miso),
    .m_mosi_o      (m_mosi),
    .m_sclk_o      (m_sclk),
    .m_cs_o        (m_cs),
    .s_data_in_bi  (s_data_in),
    .s_ready_o     (s_ready),
    .s_data_out_bo (s_data_out),
    .s_miso_o      (s_miso),
    .s_mosi_i      (s_mosi),
    .s_sclk_i      (s_sclk),
    .s_cs_i        (s_cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic sclk, input logic mosi, input int cycles);
    b_cs   = cs;
    b_sclk = sclk;
    b_mosi = mosi;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doTransfer(input logic [7:0] mtx, input logic [7:0] stx,
                            input logic [7:0] exp_m, input logic [7:0] exp_s,
                            input bit hold, input bit chk_prev,
                            input logic [7:0] prev_s, input string tag);
    int   guard;
    int   low_cycles;
    int   rises;
    logic last_sclk;
    m_data_in = mtx;
    s_data_in = stx;
    m_start   = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_ready && guard < 10);
    checkOutput({tag, "_busy"}, 32'(m_ready), 32'd0);
    low_cycles = 1;
    rises      = 0;
    last_sclk  = m_sclk;
    while (guard < 300) begin
      @(negedge clk);
      guard++;
      if (!hold && low_cycles == 1) m_start = 1'b0;
      if (chk_prev && low_cycles == 3) checkOutput({tag, "_prev_srx"}, 32'(s_data_out), 32'(prev_s));
      if (m_sclk && !last_sclk) rises++;
      last_sclk = m_sclk;
      if (m_ready) break;
      low_cycles++;
    end
    checkOutput({tag, "_ready_low"}, 32'(low_cycles), 32'(EXP_LOW));
    checkOutput({tag, "_sclk_pulses"}, 32'(rises), 32'd8);
    checkOutput({tag, "_mrx"}, 32'(m_data_out), 32'(exp_m));
    checkOutput({tag, "_cs_gap"}, 32'(m_cs), 32'd1);
    if (!hold) begin
      repeat (4) @(negedge clk);
      checkOutput({tag, "_srx"}, 32'(s_data_out), 32'(exp_s));
      checkOutput({tag, "_sready"}, 32'(s_ready), 32'd1);
    end
  endtask

  initial begin
    int guard;
    int rises;
    logic last_sclk;

    rst       = 1'b0;
    m_start   = 1'b0;
    m_data_in = 8'h00;
    s_data_in = 8'h00;
    direct    = 1'b0;
    b_cs      = 1'b1;
    b_sclk    = 1'b0;
    b_mosi    = 1'b0;

    // Reset values
    repeat (5) @(negedge clk);
    checkOutput("rst_mready", 32'(m_ready), 32'd1);
    checkOutput("rst_mcs", 32'(m_cs), 32'd1);
    checkOutput("rst_msclk", 32'(m_sclk), 32'd0);
    checkOutput("rst_mmosi", 32'(m_mosi), 32'd0);
    checkOutput("rst_mrx", 32'(m_data_out), 32'd0);
    checkOutput("rst_sready", 32'(s_ready), 32'd1);
    checkOutput("rst_smiso", 32'(s_miso), 32'd0);
    checkOutput("rst_srx", 32'(s_data_out), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_mready", 32'(m_ready), 32'd1);
    checkOutput("idle_sready", 32'(s_ready), 32'd1);

    // Basic exchange
    doTransfer(8'h5A, 8'h69, 8'h69, 8'h5A, 1'b0, 1'b0, 8'h00, "basic");

    // Back-to-back all-ones / all-zeros
    doTransfer(8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, "b2b_a");
    doTransfer(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, "b2b_b");

    // Reset in the middle of a transfer
    m_data_in = 8'h77;
    s_data_in = 8'h11;
    m_start   = 1'b1;
    rises     = 0;
    guard     = 0;
    last_sclk = m_sclk;
    while (rises < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (!m_ready) m_start = 1'b0;
      if (m_sclk && !last_sclk) rises++;
      last_sclk = m_sclk;
    end
    checkOutput("midrst_pulses", 32'(rises), 32'd3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_mcs", 32'(m_cs), 32'd1);
    checkOutput("midrst_msclk", 32'(m_sclk), 32'd0);
    checkOutput("midrst_mready", 32'(m_ready), 32'd1);
    checkOutput("midrst_mrx", 32'(m_data_out), 32'd0);
    checkOutput("midrst_sready", 32'(s_ready), 32'd1);
    checkOutput("midrst_srx", 32'(s_data_out), 32'd0);
    rst = 1'b1;
    m_start = 1'b0;
    repeat (2) @(negedge clk);
    doTransfer(8'hA5, 8'h3C, 8'h3C, 8'hA5, 1'b0, 1'b0, 8'h00, "post_rst");

    // Slave frame with only four clocks is discarded
    direct    = 1'b1;
    s_data_in = 8'h80;
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    checkOutput("abort_sready_busy", 32'(s_ready), 32'd0);
    checkOutput("abort_smiso_bit7", 32'(s_miso), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 6);
      applyStimulus(1'b0, 1'b0, 1'b1, 6);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 6);
    checkOutput("abort_srx_kept", 32'(s_data_out), 32'hA5);
    checkOutput("abort_sready", 32'(s_ready), 32'd1);
    checkOutput("abort_smiso_idle", 32'(s_miso), 32'd0);
    direct = 1'b0;
    repeat (2) @(negedge clk);

    // Start held high: transfers chain and pick up new data each time
    doTransfer(8'h12, 8'h34, 8'h34, 8'h12, 1'b1, 1'b0, 8'h00, "hold_a");
    doTransfer(8'hC3, 8'h81, 8'h81, 8'hC3, 1'b1, 1'b1, 8'h12, "hold_b");
    doTransfer(8'h0F, 8'hF0, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'hC3, "hold_c");

    repeat (5) @(negedge clk);
    checkOutput("final_mready", 32'(m_ready), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
